// File: rtl/shop_pkg.sv
// Shared definitions for the shop_v self-test sweep: state encoding, index width,
// golden truth table and the i_code gate selectors.
package shop_pkg;

    localparam int IDX_W = 5;

    // Byte per i_code: {XNOR3, NOR3, NAND3, XOR3}, bit {a,b,c} within each byte.
    localparam logic [31:0] SHOP_GOLDEN = 32'h69017F96;

    localparam logic [1:0] CODE_XOR3  = 2'b00;
    localparam logic [1:0] CODE_NAND3 = 2'b01;
    localparam logic [1:0] CODE_NOR3  = 2'b10;
    localparam logic [1:0] CODE_XNOR3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shop_sweep_timer_v.sv
// Reloadable 4-bit settle down-counter; o_zero marks the cycle a vector may be sampled.
module shop_sweep_timer_v (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= 4'd0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_dec && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign o_zero = (cnt == 4'd0);

endmodule

// File: rtl/shop_sweep_v.sv
// Sweeps shop_v through all 32 {i_code,a,b,c} vectors and captures o_f into a table.
// Define SHOP_SWEEP_CHECK_EN to compare each sample against GOLDEN (o_pass/o_fail_idx).
module shop_sweep_v
    import shop_pkg::*;
#(
    parameter int unsigned  SETTLE_CYCLES = 1,
    parameter logic [31:0]  GOLDEN        = SHOP_GOLDEN
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_f,
    output logic             o_a,
    output logic             o_b,
    output logic             o_c,
    output logic [1:0]       o_code,
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_table,
    output logic             o_pass,
    output logic [IDX_W-1:0] o_fail_idx
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             t_zero;
    logic             start_ok;
    logic             sample;

    // Start is only honoured outside RUN, and abort always beats it.
    assign start_ok = (state != ST_RUN) && i_start && !i_abort;
    assign sample   = (state == ST_RUN) && t_zero && !i_abort;

    shop_sweep_timer_v u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (start_ok || sample),
        .i_load_val (SETTLE),
        .i_dec      (state == ST_RUN),
        .o_zero     (t_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            o_table <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (i_abort) begin
                        state  <= ST_IDLE;
                        idx    <= '0;
                        o_busy <= 1'b0;
                    end else if (sample) begin
                        o_table[idx] <= i_f;
                        idx          <= idx + 5'd1;
                        if (idx == 5'd31) begin
                            state  <= ST_DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start_ok) begin
                        state   <= ST_RUN;
                        idx     <= '0;
                        o_table <= '0;
                        o_busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // idx is itself a register, so the drive bits only move on sample edges.
    assign o_a    = idx[2];
    assign o_b    = idx[1];
    assign o_c    = idx[0];
    assign o_code = idx[4:3];

`ifdef SHOP_SWEEP_CHECK_EN
    logic seen;
    logic mismatch;

    assign mismatch = (i_f != GOLDEN[idx]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seen       <= 1'b0;
            o_pass     <= 1'b0;
            o_fail_idx <= '0;
        end else if (start_ok) begin
            seen       <= 1'b0;
            o_pass     <= 1'b0;
            o_fail_idx <= '0;
        end else if (sample) begin
            if (mismatch && !seen) begin
                seen       <= 1'b1;
                o_fail_idx <= idx;
            end
            if (idx == 5'd31) begin
                o_pass <= !(seen || mismatch);
            end
        end
    end
`else
    assign o_pass     = 1'b0;
    assign o_fail_idx = '0;
`endif

endmodule

// File: tb/tb_shop_sweep_v.sv
// Directed bench: two sweepers (SETTLE 1 and 0), each closed through a behavioural shop_v.
module tb_shop_sweep_v;

`ifdef SHOP_SWEEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] start = '0, abort = '0, frc = '0, f;
    logic [1:0] av, bv, cv, busy, done, pass;
    logic [1:0][1:0]  codev;
    logic [1:0][31:0] tbl;
    logic [1:0][4:0]  fidx;
    logic [4:0] didx0, didx1;

    int nchk = 0;
    int nerr = 0;
    int lat, bcnt, nd;

    always #5 clk = ~clk;

    function automatic logic shop(input logic [1:0] code, input logic a, b, c);
        case (code)
            2'b00:   return a ^ b ^ c;
            2'b01:   return ~(a & b & c);
            2'b10:   return ~(a | b | c);
            default: return ~(a ^ b ^ c);
        endcase
    endfunction

    always_comb begin
        f = '0;
        for (int k = 0; k < 2; k++)
            f[k] = frc[k] ? 1'b0 : shop(codev[k], av[k], bv[k], cv[k]);
    end

    assign didx0 = {codev[0], av[0], bv[0], cv[0]};
    assign didx1 = {codev[1], av[1], bv[1], cv[1]};

    shop_sweep_v #(.SETTLE_CYCLES(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]), .i_f(f[0]),
        .o_a(av[0]), .o_b(bv[0]), .o_c(cv[0]), .o_code(codev[0]), .o_busy(busy[0]),
        .o_done(done[0]), .o_table(tbl[0]), .o_pass(pass[0]), .o_fail_idx(fidx[0])
    );

    shop_sweep_v #(.SETTLE_CYCLES(0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]), .i_f(f[1]),
        .o_a(av[1]), .o_b(bv[1]), .o_c(cv[1]), .o_code(codev[1]), .o_busy(busy[1]),
        .o_done(done[1]), .o_table(tbl[1]), .o_pass(pass[1]), .o_fail_idx(fidx[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start instance k at the next edge (E0); return edges from E0 to o_done and busy cycles.
    task automatic run(input int k, input bit hold, output int l, output int b);
        start[k] = 1'b1;
        tick();
        if (!hold) start[k] = 1'b0;
        l = 0;
        b = 0;
        while (l < 2000) begin
            if (busy[k]) b++;
            if (done[k]) break;
            tick();
            l++;
        end
    endtask

    task automatic wait_idx(input int k, input logic [4:0] target);
        int n = 0;
        while ((k == 0 ? didx0 : didx1) != target && n < 500) begin
            tick();
            n++;
        end
        check("wait_idx_timeout", 32'(n < 500), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_busy",  {30'd0, busy}, 32'd0);
        check("rst_done",  {30'd0, done}, 32'd0);
        check("rst_table", tbl[0] | tbl[1], 32'd0);
        check("rst_drive", {22'd0, didx0, didx1}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: reset mid-sweep clears everything immediately
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_idx(0, 5'd10);
        check("t1_busy_pre", {31'd0, busy[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_busy",  {31'd0, busy[0]}, 32'd0);
        check("t1_drive", {27'd0, didx0}, 32'd0);
        check("t1_table", tbl[0], 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t1_idle_busy",  {31'd0, busy[0]}, 32'd0);
        check("t1_idle_drive", {27'd0, didx0}, 32'd0);

        // 2: SETTLE=1 full sweep
        run(0, 1'b0, lat, bcnt);
        check("t2_latency", 32'(lat), 32'd64);
        check("t2_busy_cycles", 32'(bcnt), 32'd64);
        check("t2_table", tbl[0], 32'h69017F96);
        check("t2_pass", {31'd0, pass[0]}, {31'd0, CHK});
        check("t2_fail_idx", {27'd0, fidx[0]}, 32'd0);
        check("t2_busy_done", {31'd0, busy[0]}, 32'd0);
        tick();
        check("t2_done_pulse", {31'd0, done[0]}, 32'd0);
        tick();
        check("t2_table_stable", tbl[0], 32'h69017F96);

        // 3: SETTLE=0 full sweep
        run(1, 1'b0, lat, bcnt);
        check("t3_latency", 32'(lat), 32'd32);
        check("t3_busy_cycles", 32'(bcnt), 32'd32);
        check("t3_table", tbl[1], 32'h69017F96);
        check("t3_pass", {31'd0, pass[1]}, {31'd0, CHK});

        // 4: stuck-at-0 feedback
        tick();
        frc[1] = 1'b1;
        run(1, 1'b0, lat, bcnt);
        frc[1] = 1'b0;
        check("t4_latency", 32'(lat), 32'd32);
        check("t4_table", tbl[1], 32'd0);
        check("t4_pass", {31'd0, pass[1]}, 32'd0);
        check("t4_fail_idx", {27'd0, fidx[1]}, CHK ? 32'd1 : 32'd0);

        // 5: start held through RUN: one sweep, then restart straight out of DONE
        tick();
        run(1, 1'b1, lat, bcnt);
        check("t5_latency", 32'(lat), 32'd32);
        check("t5_table", tbl[1], 32'h69017F96);
        tick();
        check("t5_restart_busy", {31'd0, busy[1]}, 32'd1);
        check("t5_restart_done", {31'd0, done[1]}, 32'd0);
        check("t5_restart_table", tbl[1], 32'd0);
        start[1] = 1'b0;
        abort[1] = 1'b1;
        tick();
        abort[1] = 1'b0;
        check("t5_abort_busy", {31'd0, busy[1]}, 32'd0);

        // 6: abort at idx 20 keeps partial table
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_idx(0, 5'd20);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        check("t6_busy",  {31'd0, busy[0]}, 32'd0);
        check("t6_drive", {27'd0, didx0}, 32'd0);
        check("t6_table", tbl[0], 32'h00017F96);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (done[0]) nd++;
            tick();
        end
        check("t6_no_done", 32'(nd), 32'd0);
        check("t6_table_hold", tbl[0], 32'h00017F96);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
